// File: rtl/convolve_mac.sv
// Pipelined multiply-accumulate for the convolution front end: product, accumulate,
// then round/saturate into a ready/valid output register. Stalls as a whole on backpressure.
module convolve_mac #(
  parameter int PIX_W     = 8,
  parameter int COEF_W    = 8,
  parameter int COEF_FRAC = 4,
  parameter int TAPS      = 9,
  parameter int ACC_W     = 24,
  parameter int OUT_W     = 16,
  parameter int OUT_FRAC  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIX_W-1:0]       in_pix,
  input  logic [COEF_W-1:0]      in_coef,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_sat,
  output logic [$clog2(TAPS):0]  tap_cnt
);
  localparam int PW     = PIX_W + COEF_W + 1;
  localparam int SH     = COEF_FRAC - OUT_FRAC;
  localparam int TW     = $clog2(TAPS) + 1;
  localparam int STAGES = 2;
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((longint'(1) <<< (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] MINV = -MAXV - 1;

  logic                    en, rdy_q, acc_in, p_last, acc_empty;
  logic [STAGES:1]         vld_pipe;
  logic signed [PW-1:0]    prod_c, prod_q;
  logic signed [ACC_W-1:0] acc_q, fsum_q, sum_c;
  logic signed [ACC_W:0]   r_c;
  logic [TW-1:0]           tap_q;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = rdy_q && en;
  assign acc_in   = in_valid && in_ready && !flush;
  assign tap_cnt  = tap_q;
  assign prod_c   = PW'($signed({1'b0, in_pix})) * PW'($signed(in_coef));
  assign sum_c    = (acc_empty ? '0 : acc_q) + ACC_W'(prod_q);

  // Stage 1 (product) and stage 2 (accumulate). A finished window's sum moves to
  // fsum_q so the next window can start accumulating on the very next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q     <= 1'b0;
      vld_pipe  <= '0;
      p_last    <= 1'b0;
      prod_q    <= '0;
      tap_q     <= '0;
      acc_q     <= '0;
      acc_empty <= 1'b1;
      fsum_q    <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (flush) begin
        vld_pipe[1] <= 1'b0;
        tap_q       <= '0;
      end else if (en) begin
        vld_pipe[1] <= acc_in;
        if (acc_in) begin
          prod_q <= prod_c;
          p_last <= (tap_q == TW'(TAPS-1));
          tap_q  <= (tap_q == TW'(TAPS-1)) ? '0 : tap_q + 1'b1;
        end
      end
      if (en) begin
        vld_pipe[2] <= vld_pipe[1] && p_last && !flush;
        if (vld_pipe[1] && p_last && !flush) fsum_q <= sum_c;
      end
      if (flush) begin
        acc_q     <= '0;
        acc_empty <= 1'b1;
      end else if (en && vld_pipe[1]) begin
        if (p_last) acc_empty <= 1'b1;
        else begin
          acc_q     <= sum_c;
          acc_empty <= 1'b0;
        end
      end
    end
  end

  // Round half up; the extra MSB keeps the rounding add from wrapping.
  if (SH > 0) begin : g_rnd
    assign r_c = ($signed({fsum_q[ACC_W-1], fsum_q}) + (ACC_W+1)'(1 << (SH-1))) >>> SH;
  end else begin : g_nornd
    assign r_c = {fsum_q[ACC_W-1], fsum_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      out_valid <= vld_pipe[2];
      if (vld_pipe[2]) begin
        if (r_c > MAXV) begin
          out_data <= {1'b0, {(OUT_W-1){1'b1}}};
          out_sat  <= 1'b1;
        end else if (r_c < MINV) begin
          out_data <= {1'b1, {(OUT_W-1){1'b0}}};
          out_sat  <= 1'b1;
        end else begin
          out_data <= r_c[OUT_W-1:0];
          out_sat  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_convolve_mac.sv
// Scoreboard bench for convolve_mac: a second instance with OUT_FRAC=2 covers rounding.
module tb_convolve_mac;
  logic clk = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic [7:0] in_pix = 0, in_coef = 0;
  logic in_ready, out_valid, out_sat, in_ready2, out_valid2, out_sat2;
  logic [15:0] out_data, out_data2;
  logic [4:0] tap_cnt, tap_cnt2;

  typedef struct { logic [15:0] d; logic s; } exp_t;
  exp_t q1[$], q2[$];
  int n_cmp = 0, n_err = 0;
  bit chk2 = 0;
  longint wsum = 0;
  int wtaps = 0;

  always #5 clk = ~clk;

  convolve_mac dut (.clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_pix(in_pix), .in_coef(in_coef), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat), .tap_cnt(tap_cnt));

  convolve_mac #(.OUT_FRAC(2)) dut2 (.clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_pix(in_pix), .in_coef(in_coef),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_sat(out_sat2), .tap_cnt(tap_cnt2));

  function automatic exp_t model(longint sum, int sh);
    longint r;
    exp_t e;
    r = sum;
    if (sh > 0) r = (sum + (longint'(1) << (sh-1))) >>> sh;
    if (r > 32767) begin e.d = 16'h7fff; e.s = 1; end
    else if (r < -32768) begin e.d = 16'h8000; e.s = 1; end
    else begin e.d = r[15:0]; e.s = 0; end
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] p, input logic [7:0] c);
    int g = 0;
    @(negedge clk);
    in_valid = 1; in_pix = p; in_coef = c;
    #1;
    while (!in_ready && g < 100) begin @(negedge clk); #1; g++; end
    if (g >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready stuck low for %0d cycles, expected 1", g);
    end
    @(posedge clk);
    wsum += longint'(p) * longint'($signed(c));
    wtaps++;
    if (wtaps == 9) begin
      q1.push_back(model(wsum, 0));
      if (chk2) q2.push_back(model(wsum, 2));
      wsum = 0; wtaps = 0;
    end
  endtask

  task automatic idle;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic monitor;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q1.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: data %h with empty scoreboard", out_data);
        end else begin
          e = q1.pop_front();
          if (out_data !== e.d || out_sat !== e.s) begin
            n_err++;
            $display("FAIL result: got %h sat %b expected %h sat %b", out_data, out_sat, e.d, e.s);
          end
        end
      end
      if (chk2 && out_valid2 && out_ready) begin
        n_cmp++;
        if (q2.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out2: data %h with empty scoreboard", out_data2);
        end else begin
          e = q2.pop_front();
          if (out_data2 !== e.d || out_sat2 !== e.s) begin
            n_err++;
            $display("FAIL result_rnd: got %h sat %b expected %h sat %b", out_data2, out_sat2, e.d, e.s);
          end
        end
      end
    end
  endtask

  task automatic drain;
    int g = 0;
    while ((q1.size() != 0 || q2.size() != 0) && g < 200) begin @(negedge clk); g++; end
    n_cmp++;
    if (g >= 200) begin
      n_err++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", q1.size() + q2.size());
    end
    repeat (4) @(negedge clk);
    #3;
    chk("no_extra_out", out_valid, 0);
  endtask

  task automatic test_reset;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_tap_cnt", tap_cnt, 0);
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", in_ready, 1);
  endtask

  task automatic test_basic;
    for (int i = 0; i < 9; i++) send(8'd10, 8'h18);
    #1;
    chk("tap_wrap", tap_cnt, 0);
    @(negedge clk); in_valid = 0; #1;
    chk("lat_e0", out_valid, 0);
    @(negedge clk); #1;
    chk("lat_e1", out_valid, 0);
    @(negedge clk); #1;
    chk("lat_e2", out_valid, 1);
    chk("basic_data", out_data, 16'h0870);
    drain();
  endtask

  task automatic test_sat;
    for (int i = 0; i < 9; i++) send(8'd255, 8'h10);
    for (int i = 0; i < 9; i++) send(8'd255, 8'h80);
    idle();
    drain();
  endtask

  task automatic test_round;
    chk2 = 1;
    for (int i = 0; i < 9; i++) send(8'd1, 8'h02);
    idle();
    drain();
    chk2 = 0;
  endtask

  task automatic test_back_to_back;
    fork
      begin
        for (int i = 0; i < 27; i++) send(8'((i * 37 + 5) % 256), 8'((i * 13) % 256));
        idle();
      end
      begin
        int g = 0;
        @(negedge clk);
        while (!out_valid && g < 200) begin @(negedge clk); g++; end
        if (g >= 200) begin
          n_cmp++; n_err++;
          $display("FAIL stall_wait: out_valid never rose, expected a result");
        end
        out_ready = 0;
        for (int k = 0; k < 5; k++) begin
          #1;
          chk("stall_in_ready", in_ready, 0);
          chk("stall_hold_valid", out_valid, 1);
          chk("stall_hold_data", out_data, q1[0].d);
          @(negedge clk);
        end
        out_ready = 1;
        #1;
        chk("unstall_in_ready", in_ready, 1);
      end
    join
    drain();
  endtask

  task automatic test_flush;
    for (int i = 0; i < 4; i++) send(8'd7, 8'h10);
    @(negedge clk);
    flush = 1; in_valid = 1; in_pix = 8'd99; in_coef = 8'h10;
    #1;
    chk("flush_in_ready", in_ready, 1);
    @(posedge clk);
    wsum = 0; wtaps = 0;
    @(negedge clk);
    flush = 0; in_valid = 0;
    #1;
    chk("flush_tap_cnt", tap_cnt, 0);
    for (int i = 0; i < 9; i++) send(8'd2, 8'h10);
    idle();
    drain();
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) send(8'd3, 8'h10);
    @(negedge clk); in_valid = 0; #1;
    chk("pre_rst_tap_cnt", tap_cnt, 5);
    reset_n = 0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_tap_cnt", tap_cnt, 0);
    @(negedge clk); reset_n = 1;
    wsum = 0; wtaps = 0;
    send(8'd4, 8'h20);
    #1;
    chk("restart_tap_cnt", tap_cnt, 1);
    for (int i = 1; i < 9; i++) send(8'd4, 8'h20);
    idle();
    drain();
  endtask

  initial begin
    fork monitor(); join_none
    test_reset();
    test_basic();
    test_sat();
    test_round();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/convolve_mac.md
Name: convolve_mac

Overview:
- Pipelined, parametrised multiply-accumulate engine for the convolution/census front end.
- Accepts a stream of (unsigned pixel, signed fixed-point coefficient) pairs, one per kernel tap.
- After TAPS accepted pairs, emits one rounded, saturated signed fixed-point result per window.
- Uses ready/valid handshakes on both sides, with backpressure and a synchronous flush.
- Successor to the single-product multiplier: adds parametrised width and taps, an internal accumulator, rounding, saturation with flag, and flow control.

Parameters:
- PIX_W, 8: unsigned pixel width.
- COEF_W, 8: signed coefficient width.
- COEF_FRAC, 4: fractional bits in coefficient (default 4.4).
- TAPS, 9: pairs accumulated per output; legal range 1..256.
- ACC_W, 24: signed accumulator width; must be >= PIX_W+COEF_W+1+clog2(TAPS).
- OUT_W, 16: signed output width.
- OUT_FRAC, 4: output fractional bits; must be <= COEF_FRAC.

Ports:
- clk, in, 1: clock, rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- flush, in, 1: synchronous abort of the partial window.
- in_valid, in, 1: input pair valid.
- in_ready, out, 1: block can accept a pair.
- in_pix, in, PIX_W: pixel intensity, unsigned.
- in_coef, in, COEF_W: kernel coefficient, signed, COEF_FRAC fraction bits.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- out_data, out, OUT_W: result, signed, OUT_FRAC fraction bits.
- out_sat, out, 1: result was clipped; qualified by out_valid.
- tap_cnt, out, clog2(TAPS)+1: taps accepted in the current window (debug).

Behaviour:
- Reset (async, reset_n=0): in_ready=0 while asserted; out_valid=0, out_data=0, out_sat=0, tap_cnt=0; accumulator and product register cleared.
- After deassertion: in_ready=1 from the first edge.
- Stall enable: en = !(out_valid && !out_ready).
  - in_ready = en.
  - All pipeline registers hold when en=0, so no data is lost or duplicated.
- Accept: a pair is accepted on a rising edge with in_valid && in_ready.
- Stage 1 (product):
  - prod = {1'b0,in_pix} * in_coef, signed, PIX_W+COEF_W+1 bits.
  - Registered together with p_valid and p_last (p_last=1 when this is tap TAPS-1).
- Stage 2 (accumulate):
  - On p_valid && en: acc = (acc_empty ? 0 : acc) + sign_ext(prod).
  - If p_last: the scaled result is written to the output register, out_valid=1, and the accumulator is marked empty.
- Scaling: sh = COEF_FRAC-OUT_FRAC.
  - If sh>0: r = (sum + 2^(sh-1)) >>> sh (round half up, arithmetic shift).
  - If sh=0: r = sum.
- Saturation:
  - If r > 2^(OUT_W-1)-1: out_data = max positive, out_sat=1.
  - If r < -2^(OUT_W-1): out_data = min negative, out_sat=1.
  - Otherwise out_data = r[OUT_W-1:0], out_sat=0.
- Latency: out_valid rises on the 2nd rising edge after the edge accepting the final tap, with no stalls.
- Throughput: 1 pair per clock; back-to-back windows allowed with no bubble.
- Tap counter: increments per accepted pair and wraps TAPS-1 -> 0 on the final tap. tap_cnt reports the counter.
- Output hold: out_valid, out_data and out_sat are held stable until out_valid && out_ready. A new result may load on that same edge (en=1).
- Flush (flush=1 on an edge):
  - Clears tap counter, p_valid and the accumulator.
  - Any pair presented that cycle is dropped, and in_ready is still 1.
  - Does not affect a pending output register.
  - Flush and reset_n together: reset wins.
- Reset mid-window: partial sums are discarded and no output is produced for that window.
- Simultaneous out_ready and a final tap in stage 2 while out_valid=1: the old result is consumed and the new one loads on the same edge.

Test Plan:
- Defaults; 9 pairs pix=10, coef=0x18 (1.5), out_ready=1 -> one out_valid pulse, 2 clks after the 9th accept, out_data=0x0870 (135.0), out_sat=0.
- 9 pairs pix=255, coef=0x10 -> out_data=0x7FFF, out_sat=1. Then 9 pairs pix=255, coef=0x80 -> out_data=0x8000, out_sat=1.
- OUT_FRAC=2; 9 pairs pix=1, coef=0x02 (sum 18 at frac 4) -> out_data=5 (1.25), confirming rounding.
- 27 continuous pairs; out_ready held 0 for 5 clks after the first result -> in_ready=0 exactly while stalled. Three results in order, none lost or duplicated.
- flush after 4 taps, then 9 fresh pairs pix=2, coef=0x10 -> single result 0x0120 (18.0); the earlier taps are excluded.
- reset_n low for 1 clk after 5 taps -> all outputs 0 immediately. Next 9 pairs produce a correct result, and tap_cnt restarts at 0.
